// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and default widths for alu_arbiter
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 64;
    localparam int DEFAULT_OPCODE_LENGTH = 4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational AND/OR/ADD/SUB unit; unknown codes yield zero
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int OPCODE_LENGTH = DEFAULT_OPCODE_LENGTH
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] ALUCC,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam logic [OPCODE_LENGTH-1:0] L_AND = OPCODE_LENGTH'(OP_AND);
    localparam logic [OPCODE_LENGTH-1:0] L_OR  = OPCODE_LENGTH'(OP_OR);
    localparam logic [OPCODE_LENGTH-1:0] L_ADD = OPCODE_LENGTH'(OP_ADD);
    localparam logic [OPCODE_LENGTH-1:0] L_SUB = OPCODE_LENGTH'(OP_SUB);

    always_comb begin
        ALUResult = '0;
        case (ALUCC)
            L_AND:   ALUResult = SrcA & SrcB;
            L_OR:    ALUResult = SrcA | SrcB;
            L_ADD:   ALUResult = SrcA + SrcB;
            L_SUB:   ALUResult = SrcA - SrcB;
            default: ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester front end sharing one ALU; ALU_ARB_RR_EN selects round-robin arbitration
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int OPCODE_LENGTH = DEFAULT_OPCODE_LENGTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*DATA_WIDTH-1:0]    req_a,
    input  logic [2*DATA_WIDTH-1:0]    req_b,
    input  logic [2*OPCODE_LENGTH-1:0] req_op,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_id,
    output logic [DATA_WIDTH-1:0]      resp_data,
    output logic                       resp_err
);

    localparam logic [OPCODE_LENGTH-1:0] L_AND = OPCODE_LENGTH'(OP_AND);
    localparam logic [OPCODE_LENGTH-1:0] L_OR  = OPCODE_LENGTH'(OP_OR);
    localparam logic [OPCODE_LENGTH-1:0] L_ADD = OPCODE_LENGTH'(OP_ADD);
    localparam logic [OPCODE_LENGTH-1:0] L_SUB = OPCODE_LENGTH'(OP_SUB);

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       w_winner;
    logic                       w_accept;
    logic [DATA_WIDTH-1:0]      r_a;
    logic [DATA_WIDTH-1:0]      r_b;
    logic [OPCODE_LENGTH-1:0]   r_op;
    logic                       r_id;
    logic [DATA_WIDTH-1:0]      r_res;
    logic                       r_res_id;
    logic                       r_res_err;
    logic [DATA_WIDTH-1:0]      w_alu_result;
    logic                       w_op_err;
    logic                       w_in_resp;

`ifdef ALU_ARB_RR_EN
    // r_ptr names the requester that wins a tie: the one not granted last
    logic r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_winner;
        end
    end

    always_comb w_winner = (&req_valid) ? r_ptr : ~req_valid[0];
`else
    always_comb w_winner = ~req_valid[0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 2'b00;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|req_valid) && !reset) begin
                    req_ready    = w_winner ? 2'b10 : 2'b01;
                    w_accept     = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    alu #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_LENGTH(OPCODE_LENGTH)
    ) u_alu (
        .SrcA     (r_a),
        .SrcB     (r_b),
        .ALUCC    (r_op),
        .ALUResult(w_alu_result)
    );

    always_comb w_op_err = !((r_op == L_AND) || (r_op == L_OR) ||
                             (r_op == L_ADD) || (r_op == L_SUB));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_id      <= 1'b0;
            r_res     <= '0;
            r_res_id  <= 1'b0;
            r_res_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= w_winner ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
                r_b  <= w_winner ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
                r_op <= w_winner ? req_op[2*OPCODE_LENGTH-1:OPCODE_LENGTH] : req_op[OPCODE_LENGTH-1:0];
                r_id <= w_winner;
            end
            if (r_state == ST_EXEC) begin
                r_res     <= w_op_err ? '0 : w_alu_result;
                r_res_id  <= r_id;
                r_res_err <= w_op_err;
            end
        end
    end

    always_comb begin
        w_in_resp  = (r_state == ST_RESP);
        resp_valid = w_in_resp;
        resp_data  = w_in_resp ? r_res : '0;
        resp_id    = w_in_resp & r_res_id;
        resp_err   = w_in_resp & r_res_err;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;

    localparam int DW = 64;
    localparam int OL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*DW-1:0]   req_a;
    logic [2*DW-1:0]   req_b;
    logic [2*OL-1:0]   req_op;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DW-1:0]     resp_data;
    logic              resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: one outstanding transaction, result shown one cycle after accept
    logic          m_pend;
    logic          m_shown;
    logic [DW-1:0] m_data;
    logic          m_id;
    logic          m_err;
    logic          m_ptr;

    function automatic logic [DW:0] model_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OL-1:0] op);
        case (op)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a | b};
            4'd2:    return {1'b0, a + b};
            4'd6:    return {1'b0, a - b};
            default: return {1'b1, {DW{1'b0}}};
        endcase
    endfunction

    function automatic logic model_winner();
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            return m_ptr;
`else
            return 1'b0;
`endif
        end
        return req_valid[0] ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [1:0] exp_req_ready();
        if (reset || m_pend || req_valid == 2'b00) return 2'b00;
        return model_winner() ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend  <= 1'b0;
            m_shown <= 1'b0;
            m_data  <= '0;
            m_id    <= 1'b0;
            m_err   <= 1'b0;
            m_ptr   <= 1'b0;
        end else if (!m_pend) begin
            if (req_valid != 2'b00) begin
                m_pend  <= 1'b1;
                m_shown <= 1'b0;
                m_id    <= model_winner();
                m_ptr   <= ~model_winner();
                {m_err, m_data} <= model_winner() ?
                    model_alu(req_a[2*DW-1:DW], req_b[2*DW-1:DW], req_op[2*OL-1:OL]) :
                    model_alu(req_a[DW-1:0], req_b[DW-1:0], req_op[OL-1:0]);
            end
        end else if (!m_shown) begin
            m_shown <= 1'b1;
        end else if (resp_ready) begin
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic ev;
        ev = m_pend && m_shown && !reset;
        check("cmp_req_ready", 64'(req_ready), 64'(exp_req_ready()));
        check("cmp_resp_valid", 64'(resp_valid), 64'(ev));
        check("cmp_resp_data", resp_data, ev ? m_data : 64'd0);
        check("cmp_resp_id", 64'(resp_id), 64'(ev & m_id));
        check("cmp_resp_err", 64'(resp_err), 64'(ev & m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) return;
        end
        cyc = 99;
    endtask

    logic [DW-1:0] q_data[$];
    logic          q_id[$];
    logic [1:0]    exp_ids[4];

    initial begin
        int cyc;
        int n_seen;
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        tick();
        reset     = 1'b0;
        req_valid = 2'b00;
        tick();

        // add from requester 0
        req_a[DW-1:0] = 64'd5; req_b[DW-1:0] = 64'd3; req_op[OL-1:0] = 4'b0010;
        resp_ready = 1'b1; req_valid = 2'b01;
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        wait_resp(cyc);
        check("t1_latency", 64'(cyc), 64'd2);
        check("t1_data", resp_data, 64'd8);
        check("t1_id", 64'(resp_id), 64'd0);
        check("t1_err", 64'(resp_err), 64'd0);
        tick();

        // subtract from requester 1 with a stalled consumer
        resp_ready = 1'b0;
        req_a[2*DW-1:DW] = 64'd3; req_b[2*DW-1:DW] = 64'd5; req_op[2*OL-1:OL] = 4'b0110;
        req_valid = 2'b10;
        @(negedge clk);
        check("t2_ready", 64'(req_ready), 64'h2);
        tick();
        wait_resp(cyc);
        check("t2_latency", 64'(cyc), 64'd2);
        check("t2_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t2_id", 64'(resp_id), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_hold_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
            check("t2_hold_valid", 64'(resp_valid), 64'd1);
            check("t2_hold_ready", 64'(req_ready), 64'd0);
        end
        tick();
        resp_ready = 1'b1; req_valid = 2'b00;
        tick();

        // unsupported opcode
        req_a[DW-1:0] = 64'hFF; req_b[DW-1:0] = 64'hFF; req_op[OL-1:0] = 4'b1111;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_resp(cyc);
        check("t3_latency", 64'(cyc), 64'd2);
        check("t3_data", resp_data, 64'd0);
        check("t3_err", 64'(resp_err), 64'd1);
        tick();

        // reset while the operation is in EXEC
        req_a[2*DW-1:DW] = 64'd7; req_b[2*DW-1:DW] = 64'd9; req_op[2*OL-1:OL] = 4'b0010;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        #1 reset = 1'b1;
        #1;
        check("t4_rst_valid", 64'(resp_valid), 64'd0);
        check("t4_rst_data", resp_data, 64'd0);
        check("t4_rst_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b0;
        n_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) n_seen++;
        end
        check("t4_no_resp", 64'(n_seen), 64'd0);

        // both requesters continuously
        tick();
        req_a[DW-1:0] = 64'hF0; req_b[DW-1:0] = 64'h3C; req_op[OL-1:0] = 4'b0000;
        req_a[2*DW-1:DW] = 64'hF0; req_b[2*DW-1:DW] = 64'h0F; req_op[2*OL-1:OL] = 4'b0001;
        resp_ready = 1'b1; req_valid = 2'b11;
        for (int k = 0; k < 60 && q_id.size() < 4; k++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                q_id.push_back(resp_id);
                q_data.push_back(resp_data);
            end
        end
        tick();
        req_valid = 2'b00;
`ifdef ALU_ARB_RR_EN
        exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        check("t5_count", 64'(q_id.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < q_id.size()) begin
                check("t5_id", 64'(q_id[k]), 64'(exp_ids[k]));
                check("t5_data", q_data[k], exp_ids[k][0] ? 64'hFF : 64'h30);
            end
        end
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
